// File: rtl/lcd_ctrl.sv
// HD44780-style character-LCD write sequencer: runs the power-on init bytes,
// then serialises requested command/data bytes into RS/EN/DATA timing on lcd_o.
module lcd_ctrl #(
    parameter int T_POWER = 800000,
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 12,
    parameter int T_HOLD  = 2,
    parameter int T_CMD   = 2000,
    parameter int T_CLEAR = 82000,
    parameter int CNT_W   = 20
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lcd_on_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_rs_i,
    input  logic [7:0]  req_data_i,
    output logic        busy_o,
    output logic        init_done_o,
    output logic [31:0] lcd_o
);

    localparam logic [2:0] PWR_WAIT = 3'd0;
    localparam logic [2:0] SETUP    = 3'd1;
    localparam logic [2:0] PULSE    = 3'd2;
    localparam logic [2:0] HOLD     = 3'd3;
    localparam logic [2:0] WAIT     = 3'd4;
    localparam logic [2:0] IDLE     = 3'd5;

    // Counter reload values: a state lasting N cycles loads N-1 and exits on 0.
    localparam logic [CNT_W-1:0] LD_POWER = CNT_W'(T_POWER - 1);
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] LD_CLEAR = CNT_W'(T_CLEAR - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       init_idx;
    logic             rs_q;
    logic [7:0]       data_q;
    logic             en_q;
    logic             on_q;
    logic             ready_q;
    logic             init_done_q;
    logic             cnt_zero;
    logic             slow_cmd;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    endfunction

    assign cnt_zero = (cnt == '0);
    // Clear (0x01) and return-home (0x02/0x03) take the long execution time.
    assign slow_cmd = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

    // NOTE: every register here uses non-blocking assignment so all next-state
    // decisions read the values from before this edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= PWR_WAIT;
            cnt         <= LD_POWER;
            init_idx    <= 2'd0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            en_q        <= 1'b0;
            on_q        <= 1'b0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            on_q <= lcd_on_i;
            case (state)
                PWR_WAIT: begin
                    if (cnt_zero) begin
                        state  <= SETUP;
                        cnt    <= LD_SETUP;
                        rs_q   <= 1'b0;
                        data_q <= init_byte(2'd0);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt_zero) begin
                        state <= PULSE;
                        cnt   <= LD_PULSE;
                        en_q  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt_zero) begin
                        state <= HOLD;
                        cnt   <= LD_HOLD;
                        en_q  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_zero) begin
                        state <= WAIT;
                        cnt   <= slow_cmd ? LD_CLEAR : LD_CMD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAIT: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                    end else if (!init_done_q && init_idx != 2'd3) begin
                        init_idx <= init_idx + 2'd1;
                        rs_q     <= 1'b0;
                        data_q   <= init_byte(init_idx + 2'd1);
                        state    <= SETUP;
                        cnt      <= LD_SETUP;
                    end else begin
                        init_done_q <= 1'b1;
                        ready_q     <= 1'b1;
                        state       <= IDLE;
                    end
                end
                IDLE: begin
                    if (req_valid_i && ready_q) begin
                        rs_q    <= req_rs_i;
                        data_q  <= req_data_i;
                        ready_q <= 1'b0;
                        state   <= SETUP;
                        cnt     <= LD_SETUP;
                    end
                end
                default: begin
                    state <= PWR_WAIT;
                    cnt   <= LD_POWER;
                end
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign busy_o      = ~ready_q;
    assign init_done_o = init_done_q;
    assign lcd_o       = {on_q, 20'd0, en_q, rs_q, 1'b0, data_q};

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing; expected cycle positions
// are hand-derived from the timing parameters below.
module tb_lcd_ctrl;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        lcd_on_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_rs_i = 1'b0;
    logic [7:0]  req_data_i = 8'h00;
    logic        busy_o;
    logic        init_done_o;
    logic [31:0] lcd_o;

    int checks = 0;
    int failures = 0;

    logic [7:0]  init_tab [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    logic [31:0] on_pat = 32'b1011_0010_1110_0101_1001_1100_0110_1011;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .T_POWER(10), .T_SETUP(2), .T_PULSE(4), .T_HOLD(2),
        .T_CMD(8), .T_CLEAR(20), .CNT_W(20)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .lcd_on_i   (lcd_on_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_rs_i   (req_rs_i),
        .req_data_i (req_data_i),
        .busy_o     (busy_o),
        .init_done_o(init_done_o),
        .lcd_o      (lcd_o)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called right after the edge that sampled reset high (k = 0); checks 90 cycles.
    task automatic run_init_check(input string tag);
        logic exp_en, exp_rdy;
        int   bi;
        for (int k = 1; k <= 90; k++) begin
            tick();
            exp_en  = (k >= 12 && k <= 15) || (k >= 28 && k <= 31) ||
                      (k >= 44 && k <= 47) || (k >= 72 && k <= 75);
            exp_rdy = (k >= 86);
            bi      = (k < 16) ? 0 : (k < 32) ? 1 : (k < 48) ? 2 : 3;
            checks++;
            if (lcd_o[10] !== exp_en) begin
                failures++;
                $display("FAIL %s_en k=%0d got=%b exp=%b", tag, k, lcd_o[10], exp_en);
            end
            checks++;
            if (req_ready_o !== exp_rdy || init_done_o !== exp_rdy || busy_o !== !exp_rdy) begin
                failures++;
                $display("FAIL %s_ready k=%0d got rdy=%b done=%b busy=%b exp rdy=%b",
                         tag, k, req_ready_o, init_done_o, busy_o, exp_rdy);
            end
            checks++;
            if ({lcd_o[31:11], lcd_o[8]} !== 22'd0) begin
                failures++;
                $display("FAIL %s_zero_bits k=%0d got=%h exp=0", tag, k, lcd_o);
            end
            if (exp_en) begin
                checks++;
                if (lcd_o[9:0] !== {2'b00, init_tab[bi]}) begin
                    failures++;
                    $display("FAIL %s_byte k=%0d got=%h exp=%h", tag, k, lcd_o[9:0],
                             {2'b00, init_tab[bi]});
                end
            end
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (req_ready_o !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL %s_wait_ready got=%b exp=1 after %0d cycles", tag, req_ready_o, n);
        end
    endtask

    // Accept one byte and check every cycle until ready returns 'total' cycles later.
    task automatic do_write(input logic rs, input logic [7:0] d, input int total,
                            input bit toggle, input string tag);
        logic [9:0] exp_lo;
        logic       prev_on;
        logic       exp_en, exp_rdy;
        checks++;
        if (req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL %s_pre_ready got=%b exp=1", tag, req_ready_o);
        end
        req_valid_i = 1'b1;
        req_rs_i    = rs;
        req_data_i  = d;
        prev_on     = lcd_on_i;
        tick();
        req_valid_i = 1'b0;
        req_rs_i    = ~rs;
        req_data_i  = ~d;
        exp_lo      = {rs, 1'b0, d};
        for (int j = 0; j <= total; j++) begin
            exp_en  = (j >= 2 && j <= 5);
            exp_rdy = (j == total);
            checks++;
            if (lcd_o[9:0] !== exp_lo || lcd_o[10] !== exp_en) begin
                failures++;
                $display("FAIL %s_lcd j=%0d got en=%b lo=%h exp en=%b lo=%h",
                         tag, j, lcd_o[10], lcd_o[9:0], exp_en, exp_lo);
            end
            checks++;
            if (req_ready_o !== exp_rdy || busy_o !== !exp_rdy) begin
                failures++;
                $display("FAIL %s_ready j=%0d got rdy=%b busy=%b exp rdy=%b",
                         tag, j, req_ready_o, busy_o, exp_rdy);
            end
            checks++;
            if (lcd_o[31] !== prev_on || lcd_o[30:11] !== 20'd0) begin
                failures++;
                $display("FAIL %s_on j=%0d got=%h exp bit31=%b upper zero", tag, j, lcd_o, prev_on);
            end
            if (j < total) begin
                if (toggle) lcd_on_i = on_pat[j];
                prev_on = lcd_on_i;
                tick();
            end
        end
    endtask

    task automatic test_reset();
        rst_i    = 1'b1;
        lcd_on_i = 1'b1;
        tick();
        tick();
        checks++;
        if (lcd_o !== 32'h0 || req_ready_o !== 1'b0 || busy_o !== 1'b1 || init_done_o !== 1'b0) begin
            failures++;
            $display("FAIL reset got lcd=%h rdy=%b busy=%b done=%b exp 0/0/1/0",
                     lcd_o, req_ready_o, busy_o, init_done_o);
        end
        rst_i    = 1'b0;
        lcd_on_i = 1'b0;
        run_init_check("init");
    endtask

    task automatic test_data_write();
        do_write(1'b1, 8'h41, 16, 1'b0, "data41");
    endtask

    task automatic test_cmd_write();
        do_write(1'b0, 8'h01, 28, 1'b0, "clear");
        do_write(1'b0, 8'h80, 16, 1'b0, "cmd80");
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        int   acc = 0;
        int   rises = 0;
        logic prev_en = lcd_o[10];
        for (int t = 0; t < 60; t++) begin
            req_valid_i = 1'b1;
            req_rs_i    = 1'b1;
            req_data_i  = 8'hA0 + 8'(t);
            if (req_ready_o === 1'b1) begin
                acc++;
                q.push_back(req_data_i);
            end
            tick();
            if (lcd_o[10] === 1'b1 && prev_en === 1'b0) begin
                rises++;
                checks++;
                if (q.size() == 0 || lcd_o[7:0] !== q[0] || lcd_o[9] !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_byte t=%0d got=%h exp=%h", t, lcd_o[9:0],
                             (q.size() != 0) ? {2'b10, q[0]} : 10'h0);
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            prev_en = lcd_o[10];
        end
        req_valid_i = 1'b0;
        checks++;
        if (acc != 4) begin
            failures++;
            $display("FAIL b2b_accepts got=%0d exp=4", acc);
        end
        checks++;
        if (rises != 4) begin
            failures++;
            $display("FAIL b2b_pulses got=%0d exp=4", rises);
        end
        wait_ready("b2b");
    endtask

    task automatic test_lcd_on();
        do_write(1'b1, 8'h5A, 16, 1'b1, "lcd_on");
        lcd_on_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        req_valid_i = 1'b1;
        req_rs_i    = 1'b1;
        req_data_i  = 8'h55;
        tick();
        req_valid_i = 1'b0;
        repeat (3) tick();
        checks++;
        if (lcd_o[10] !== 1'b1) begin
            failures++;
            $display("FAIL mid_in_pulse got en=%b exp=1", lcd_o[10]);
        end
        lcd_on_i = 1'b1;
        rst_i    = 1'b1;
        tick();
        checks++;
        if (lcd_o !== 32'h0 || init_done_o !== 1'b0 || req_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset got lcd=%h done=%b rdy=%b busy=%b exp 0/0/0/1",
                     lcd_o, init_done_o, req_ready_o, busy_o);
        end
        rst_i    = 1'b0;
        lcd_on_i = 1'b0;
        run_init_check("reinit");
    endtask

    initial begin
        test_reset();
        test_data_write();
        test_cmd_write();
        test_back_to_back();
        test_lcd_on();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
